// File: rtl/cpu_wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package cpu_wb_arb_pkg;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] word_t;

  localparam logic NOP_WB_VALID = 1'b0;
  localparam int   NUM_QRY      = 3;

  // One register-file write request (pipe side or granted result).
  typedef struct packed {
    regaddr_t addr;
    word_t    data;
    logic     valid;
  } wb_req_t;

  // Buffered MCU result; live drops when a younger pipe write squashes it
  // or when the entry pops.
  typedef struct packed {
    regaddr_t addr;
    word_t    data;
    logic     live;
  } mcu_ent_t;

  // Pending-write lookup hit; x0 never counts as pending.
  function automatic logic addr_hit(regaddr_t q, regaddr_t a, logic live);
    return live && (q != '0) && (q == a);
  endfunction

endpackage

// File: rtl/cpu_wb_arb_buf.sv
// DEPTH-entry MCU result FIFO with per-entry live bits, squash-by-address
// and pending-write lookup ports.
module cpu_wb_arb_buf
  import cpu_wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  regaddr_t                     push_addr_i,
  input  word_t                        push_data_i,
  input  logic                         pop_i,
  input  logic                         squash_i,
  input  regaddr_t                     squash_addr_i,
  input  regaddr_t [NUM_QRY-1:0]       qry_addr_i,
  output mcu_ent_t                     head_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic [NUM_QRY-1:0]           hit_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mcu_ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  // Entry update: pop kills the head, squash kills matching entries, and a
  // same-cycle push lands last so it is never squashed.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pop_i && (rd_ptr_q == PW'(i)))
        ent_d[i].live = 1'b0;
      if (squash_i && (ent_q[i].addr == squash_addr_i))
        ent_d[i].live = 1'b0;
      if (push_i && (wr_ptr_q == PW'(i)))
        ent_d[i] = '{addr: push_addr_i, data: push_data_i, live: 1'b1};
    end
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  // Storage and pointers; reset discards every entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ent_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_q    <= ent_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Lookups: live implies occupied, since pop and reset clear live.
  always_comb begin
    hit_o = '0;
    for (int q = 0; q < NUM_QRY; q++)
      for (int i = 0; i < DEPTH; i++)
        hit_o[q] = hit_o[q] | addr_hit(qry_addr_i[q], ent_q[i].addr, ent_q[i].live);
  end

  assign head_o  = ent_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cpu_wb_arb.sv
// Register-file write-port arbiter: WB pipe vs buffered multi-cycle results,
// with a starvation freeze of WB to force a drain.
module cpu_wb_arb
  import cpu_wb_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic     clk_i,
  input  logic     reset_i,
  input  regaddr_t pipe_addr_i,
  input  word_t    pipe_data_i,
  input  logic     pipe_valid_i,
  input  regaddr_t mcu_addr_i,
  input  word_t    mcu_data_i,
  input  logic     mcu_valid_i,
  output logic     mcu_ready_o,
  output regaddr_t rf_addr_o,
  output word_t    rf_data_o,
  output logic     rf_wr_en_o,
  output logic     stall_o,
  input  regaddr_t rs1_i,
  input  regaddr_t rs2_i,
  input  regaddr_t rd_i,
  output logic     rs1_pend_o,
  output logic     rs2_pend_o,
  output logic     rd_pend_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  mcu_ent_t             head;
  logic [CW-1:0]        count;
  logic [NUM_QRY-1:0]   hit;
  logic                 head_present, head_live;
  logic                 pipe_go, push, pop, stall;
  wb_req_t              pipe_req, wr;
  logic [SW-1:0]        starve_q, starve_d;

  assign pipe_req     = '{addr: pipe_addr_i, data: pipe_data_i, valid: pipe_valid_i};
  assign head_present = (count != '0);
  assign head_live    = head_present && head.live;
  assign stall        = !reset_i && (starve_q == SW'(STARVE_LIMIT)) && head_live;
  assign pipe_go      = !reset_i && pipe_req.valid && (pipe_req.addr != '0) && !stall;
  assign mcu_ready_o  = !reset_i && (count != CW'(DEPTH));
  // x0 results are accepted but never stored.
  assign push         = mcu_valid_i && mcu_ready_o && (mcu_addr_i != '0);
  // A dead head pops in any cycle; a live head pops only when it gets the port.
  assign pop          = !reset_i && head_present && !(pipe_go && head_live);

  cpu_wb_arb_buf #(.DEPTH(DEPTH)) u_buf (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .push_i        (push),
    .push_addr_i   (mcu_addr_i),
    .push_data_i   (mcu_data_i),
    .pop_i         (pop),
    .squash_i      (pipe_go),
    .squash_addr_i (pipe_req.addr),
    .qry_addr_i    ({rd_i, rs2_i, rs1_i}),
    .head_o        (head),
    .count_o       (count),
    .hit_o         (hit)
  );

  // Grant the single write port: pipe unless frozen, else a live head.
  always_comb begin
    wr = '{addr: '0, data: '0, valid: NOP_WB_VALID};
    if (pipe_go)
      wr = pipe_req;
    else if (!reset_i && head_live)
      wr = '{addr: head.addr, data: head.data, valid: 1'b1};
  end

  // Starvation count: grows while a live head loses to the pipe, clears on pop.
  always_comb begin
    starve_d = starve_q;
    if (!head_present || pop)
      starve_d = '0;
    else if (head_live && pipe_go)
      starve_d = starve_q + SW'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) starve_q <= '0;
    else         starve_q <= starve_d;
  end

  assign rf_wr_en_o = wr.valid;
  assign rf_addr_o  = wr.addr;
  assign rf_data_o  = wr.data;
  assign stall_o    = stall;
  assign rs1_pend_o = !reset_i && hit[0];
  assign rs2_pend_o = !reset_i && hit[1];
  assign rd_pend_o  = !reset_i && hit[2];

endmodule

// File: tb/tb_cpu_wb_arb.sv
module tb_cpu_wb_arb;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [4:0]  pipe_addr_i, mcu_addr_i, rf_addr_o, rs1_i, rs2_i, rd_i;
  logic [31:0] pipe_data_i, mcu_data_i, rf_data_o;
  logic        pipe_valid_i, mcu_valid_i, mcu_ready_o, rf_wr_en_o, stall_o;
  logic        rs1_pend_o, rs2_pend_o, rd_pend_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  cpu_wb_arb dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i), .pipe_valid_i(pipe_valid_i),
    .mcu_addr_i(mcu_addr_i), .mcu_data_i(mcu_data_i), .mcu_valid_i(mcu_valid_i),
    .mcu_ready_o(mcu_ready_o),
    .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o), .rf_wr_en_o(rf_wr_en_o),
    .stall_o(stall_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .rs1_pend_o(rs1_pend_o), .rs2_pend_o(rs2_pend_o), .rd_pend_o(rd_pend_o)
  );

  typedef struct {
    logic        pv;  logic [4:0] pa; logic [31:0] pd;
    logic        mv;  logic [4:0] ma; logic [31:0] md;
    logic [4:0]  r1, r2, rq;
    logic        we;  logic [4:0] wa; logic [31:0] wd;
    logic        st, rdy, p1, p2, p3;
  } vec_t;

  function automatic vec_t v(logic pv, logic [4:0] pa, logic [31:0] pd,
                             logic mv, logic [4:0] ma, logic [31:0] md,
                             logic [4:0] r1, logic [4:0] r2, logic [4:0] rq,
                             logic we, logic [4:0] wa, logic [31:0] wd,
                             logic st, logic rdy, logic p1, logic p2, logic p3);
    vec_t t;
    t.pv = pv; t.pa = pa; t.pd = pd; t.mv = mv; t.ma = ma; t.md = md;
    t.r1 = r1; t.r2 = r2; t.rq = rq; t.we = we; t.wa = wa; t.wd = wd;
    t.st = st; t.rdy = rdy; t.p1 = p1; t.p2 = p2; t.p3 = p3;
    return t;
  endfunction

  task automatic drive(logic pv, logic [4:0] pa, logic [31:0] pd,
                       logic mv, logic [4:0] ma, logic [31:0] md,
                       logic [4:0] r1, logic [4:0] r2, logic [4:0] rq);
    pipe_valid_i = pv; pipe_addr_i = pa; pipe_data_i = pd;
    mcu_valid_i  = mv; mcu_addr_i  = ma; mcu_data_i  = md;
    rs1_i = r1; rs2_i = r2; rd_i = rq;
  endtask

  // Observed outputs; address/data only matter when a write is enabled.
  function automatic logic [63:0] obs();
    return {21'd0, rf_wr_en_o, rf_wr_en_o ? rf_addr_o : 5'd0,
            rf_wr_en_o ? rf_data_o : 32'd0, stall_o, mcu_ready_o,
            rs1_pend_o, rs2_pend_o, rd_pend_o};
  endfunction

  function automatic logic [63:0] expv(logic we, logic [4:0] wa, logic [31:0] wd,
                                       logic st, logic rdy, logic p1, logic p2, logic p3);
    return {21'd0, we, we ? wa : 5'd0, we ? wd : 32'd0, st, rdy, p1, p2, p3};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Move to the next cycle's drive point (just after the rising edge).
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  vec_t        tbl[18];
  logic [31:0] dut_rf[32];
  logic [31:0] arch_rf[32];
  int          x0_writes;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Vectors: one row per cycle, expectations follow from earlier rows.
    tbl[0]  = v(0,0,0,        1,5,'h1234,   5,0,0,    0,0,0,          0,1, 0,0,0);
    tbl[1]  = v(0,0,0,        0,0,0,        5,0,0,    1,5,'h1234,     0,1, 1,0,0);
    tbl[2]  = v(0,0,0,        0,0,0,        5,0,0,    0,0,0,          0,1, 0,0,0);
    tbl[3]  = v(0,0,0,        1,3,'hA,      0,0,3,    0,0,0,          0,1, 0,0,0);
    tbl[4]  = v(1,3,'hB,      0,0,0,        0,0,3,    1,3,'hB,        0,1, 0,0,1);
    tbl[5]  = v(0,0,0,        0,0,0,        0,0,3,    0,0,0,          0,1, 0,0,0);
    tbl[6]  = v(0,0,0,        0,0,0,        3,0,3,    0,0,0,          0,1, 0,0,0);
    tbl[7]  = v(1,7,'h77,     1,10,'h10a,   0,0,0,    1,7,'h77,       0,1, 0,0,0);
    tbl[8]  = v(1,7,'h77,     1,11,'h10b,   0,0,0,    1,7,'h77,       0,1, 0,0,0);
    tbl[9]  = v(1,7,'h77,     1,12,'h10c,   0,0,0,    1,7,'h77,       0,1, 0,0,0);
    tbl[10] = v(1,7,'h77,     1,13,'h10d,   0,0,0,    1,7,'h77,       0,1, 0,0,0);
    tbl[11] = v(1,7,'h77,     1,14,'h10e,   13,14,10, 1,7,'h77,       0,0, 1,0,1);
    tbl[12] = v(0,0,0,        1,14,'h10e,   0,0,0,    1,10,'h10a,     0,0, 0,0,0);
    tbl[13] = v(0,0,0,        1,0,'hdead,   0,0,0,    1,11,'h10b,     0,1, 0,0,0);
    tbl[14] = v(0,0,0,        0,0,0,        0,0,0,    1,12,'h10c,     0,1, 0,0,0);
    tbl[15] = v(0,0,0,        0,0,0,        0,0,0,    1,13,'h10d,     0,1, 0,0,0);
    tbl[16] = v(0,0,0,        0,0,0,        0,0,0,    0,0,0,          0,1, 0,0,0);
    tbl[17] = v(1,0,'h5,      0,0,0,        0,0,0,    0,0,0,          0,1, 0,0,0);

    // Reset state, with active-looking inputs.
    reset_i = 1'b1;
    drive(1, 7, 'h55, 1, 9, 'h66, 7, 9, 9);
    next_cycle();
    #2;
    chk("reset_outputs", {21'd0, rf_wr_en_o, rf_addr_o, rf_data_o, stall_o, mcu_ready_o,
                          rs1_pend_o, rs2_pend_o, rd_pend_o}, 64'd0);
    next_cycle();
    reset_i = 1'b0;

    // Table: basic write, pend timing, squash, full buffer, x0 cases.
    foreach (tbl[i]) begin
      drive(tbl[i].pv, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md,
            tbl[i].r1, tbl[i].r2, tbl[i].rq);
      #2;
      chk($sformatf("vec%0d", i), obs(),
          expv(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].st, tbl[i].rdy,
               tbl[i].p1, tbl[i].p2, tbl[i].p3));
      next_cycle();
    end

    // Reset mid-run with three entries queued behind a busy pipe.
    for (int k = 0; k < 3; k++) begin
      drive(1, 7, 'h70 + k, 1, 5'(20 + k), 'h200 + k, 0, 0, 0);
      next_cycle();
    end
    reset_i = 1'b1;
    drive(1, 7, 'h7f, 1, 23, 'h203, 20, 21, 22);
    #2;
    chk("midreset_outputs", {21'd0, rf_wr_en_o, rf_addr_o, rf_data_o, stall_o, mcu_ready_o,
                             rs1_pend_o, rs2_pend_o, rd_pend_o}, 64'd0);
    next_cycle();
    reset_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 20, 21, 22);
      #2;
      chk($sformatf("post_reset%0d", k), obs(), expv(0, 0, 0, 0, 1, 0, 0, 0));
      next_cycle();
    end

    // Starvation: x9 queued while the pipe writes x7 every cycle.
    drive(1, 7, 'h700, 1, 9, 'h99, 0, 0, 0);
    #2;
    chk("starve_push", obs(), expv(1, 7, 'h700, 0, 1, 0, 0, 0));
    next_cycle();
    for (int k = 1; k <= 10; k++) begin
      drive(1, 7, 'h700 + k, 0, 0, 0, 9, 0, 0);
      #2;
      if (k <= 8)
        chk($sformatf("starve_pipe%0d", k), obs(), expv(1, 7, 'h700 + k, 0, 1, 1, 0, 0));
      else if (k == 9)
        chk("starve_freeze", obs(), expv(1, 9, 'h99, 1, 1, 1, 0, 0));
      else
        chk("starve_resume", obs(), expv(1, 7, 'h700 + k, 0, 1, 0, 0, 0));
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Random traffic vs architectural program-order model.
    foreach (dut_rf[i]) begin dut_rf[i] = '0; arch_rf[i] = '0; end
    x0_writes = 0;
    for (int c = 0; c < 400; c++) begin
      if (c < 360)
        drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      else
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      if (rf_wr_en_o) begin
        if (rf_addr_o == 5'd0) x0_writes++;
        dut_rf[rf_addr_o] = rf_data_o;
      end
      // Pipe write precedes a same-cycle MCU push in program order.
      if (pipe_valid_i && !stall_o && pipe_addr_i != 5'd0) arch_rf[pipe_addr_i] = pipe_data_i;
      if (mcu_valid_i && mcu_ready_o && mcu_addr_i != 5'd0) arch_rf[mcu_addr_i] = mcu_data_i;
      next_cycle();
    end
    chk("rand_x0_writes", 64'(x0_writes), 64'd0);
    for (int r = 1; r < 8; r++)
      chk($sformatf("rand_x%0d", r), {32'd0, dut_rf[r]}, {32'd0, arch_rf[r]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
